// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // Index of the lowest-numbered active-low row; 0 when none is low.
    function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the 4 keypad row lines, resets to all-ones (idle).
module sync_2ff (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_q, meta_d;
    logic [3:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: rotating active-low column strobe, row debounce, one event per press.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [3:0]       row_s;
    state_e           state_q, state_d;
    logic [3:0]       col_q, col_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_down_q, key_down_d;

    logic             row_bit;
    logic [CNT_W-1:0] cnt_inc;
    logic             adv_col, accept, release_done;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row),
        .q     (row_s)
    );

    assign row_bit = row_s[row_idx_q];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // Next-state, counter and output logic; nothing moves without an en tick.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        col_idx_d    = col_idx_q;
        row_idx_d    = row_idx_q;
        cnt_d        = cnt_q;
        key_code_d   = key_code_q;
        key_valid_d  = 1'b0;
        key_down_d   = key_down_q;
        adv_col      = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;

        if (en) begin
            unique case (state_q)
                SCAN: begin
                    if (row_s != ROWS_IDLE) begin
                        row_idx_d = low_row_idx(row_s);
                        cnt_d     = CNT_ONE;
                        if (DEBOUNCE_TICKS == 1) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        adv_col = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!row_bit) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        adv_col = 1'b1;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (row_bit) begin
                        cnt_d = CNT_ONE;
                        if (DEBOUNCE_TICKS == 1) begin
                            release_done = 1'b1;
                            adv_col      = 1'b1;
                            state_d      = SCAN;
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (row_bit) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            release_done = 1'b1;
                            adv_col      = 1'b1;
                            state_d      = SCAN;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        if (adv_col) begin
            col_d     = {col_q[2:0], col_q[3]};
            col_idx_d = col_idx_q + 2'd1;
        end
        if (accept) begin
            key_code_d  = {row_idx_d, col_idx_q};
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
        end
        if (release_done) begin
            key_down_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            col_q       <= COL_RESET;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: emulated switch matrix, behavioural model, directed scenarios.
module tb_keypad_scan;

    localparam int N = 4;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        en      = 1'b0;
    logic [15:0] pressed = 16'h0000;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;

    int n_checks = 0;
    int n_err    = 0;
    int pulses   = 0;
    int base     = 0;

    always #5 clk = ~clk;

    // Switch matrix: a row reads low when a pressed key sits on a strobed column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if ((pressed[r*4 +: 4] & ~col) != 4'h0) row[r] = 1'b0;
        end
    end

    keypad_scan #(.DEBOUNCE_TICKS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    // Behavioural model: column index, candidate row, agreeing-sample streak.
    int         m_ci = 0;
    int         m_ri = 0;
    int         m_streak = 0;
    bit         m_frozen = 1'b0;
    bit         m_down = 1'b0;
    bit         m_valid = 1'b0;
    logic [3:0] m_code = 4'h0;
    logic [3:0] m_s1 = 4'hF;
    logic [3:0] m_s2 = 4'hF;
    logic [3:0] one = 4'b0001;

    task automatic m_accept();
        m_down   = 1'b1;
        m_valid  = 1'b1;
        m_code   = 4'(m_ri * 4 + m_ci);
        m_streak = 0;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ci = 0; m_ri = 0; m_streak = 0;
            m_frozen = 1'b0; m_down = 1'b0; m_valid = 1'b0;
            m_code = 4'h0; m_s1 = 4'hF; m_s2 = 4'hF;
        end else begin
            m_valid = 1'b0;
            if (en) begin
                if (!m_frozen) begin
                    if (m_s2 != 4'hF) begin
                        for (int i = 3; i >= 0; i--) if (!m_s2[i]) m_ri = i;
                        m_frozen = 1'b1;
                        m_streak = 1;
                        if (m_streak >= N) m_accept();
                    end else begin
                        m_ci = (m_ci + 1) % 4;
                    end
                end else if (!m_down) begin
                    if (!m_s2[m_ri]) begin
                        m_streak++;
                        if (m_streak >= N) m_accept();
                    end else begin
                        m_frozen = 1'b0;
                        m_ci = (m_ci + 1) % 4;
                    end
                end else begin
                    if (m_s2[m_ri]) begin
                        m_streak++;
                        if (m_streak >= N) begin
                            m_down = 1'b0;
                            m_frozen = 1'b0;
                            m_ci = (m_ci + 1) % 4;
                        end
                    end else begin
                        m_streak = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = row;
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        chk("col", col, 4'hF & ~(one << m_ci));
        chk("key_code", key_code, m_code);
        chk("key_valid", 4'(key_valid), 4'(m_valid));
        chk("key_down", 4'(key_down), 4'(m_down));
    end

    initial forever begin
        @(negedge clk);
        if (key_valid === 1'b1) pulses++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            en = 1'b1;
            @(negedge clk);
            en = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    logic [3:0] idle_seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_col", col, 4'b1110);
        chk("reset_down", 4'(key_down), 4'h0);

        // Idle scan wraps through all four columns.
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("idle_col", col, idle_seq[i]);
        end

        // Press bounce: two low samples then released.
        base = pulses;
        pressed[9] = 1'b1; settle(); tick(3);
        pressed[9] = 1'b0; settle(); tick(1);
        chk("bounce_col", col, 4'b1011);
        chk("bounce_pulses", 4'(pulses - base), 4'h0);

        // Clean press of row 2 / col 1.
        base = pulses;
        pressed[9] = 1'b1; settle(); tick(9);
        chk("press_pulses", 4'(pulses - base), 4'h1);
        chk("press_code", key_code, 4'h9);
        chk("press_down", 4'(key_down), 4'h1);
        chk("press_col", col, 4'b1101);

        // Release bounce, re-press, then clean release.
        pressed[9] = 1'b0; settle(); tick(2);
        chk("relb_down", 4'(key_down), 4'h1);
        pressed[9] = 1'b1; settle(); tick(1);
        chk("repress_down", 4'(key_down), 4'h1);
        pressed[9] = 1'b0; settle(); tick(3);
        chk("rel3_down", 4'(key_down), 4'h1);
        tick(1);
        chk("rel_down", 4'(key_down), 4'h0);
        chk("rel_col", col, 4'b1011);
        chk("rel_pulses", 4'(pulses - base), 4'h1);

        // Two rows low in column 0: lowest row wins.
        base = pulses;
        pressed[4] = 1'b1; pressed[12] = 1'b1; settle(); tick(8);
        chk("multi_code", key_code, 4'h4);
        chk("multi_pulses", 4'(pulses - base), 4'h1);
        pressed = 16'h0000; settle(); tick(4);
        chk("multi_rel_down", 4'(key_down), 4'h0);
        chk("multi_rel_col", col, 4'b1101);

        // Reset in the middle of a debounce.
        pressed[9] = 1'b1; settle(); tick(2);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_col", col, 4'b1110);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", 4'(key_valid), 4'h0);
        chk("rst_down", 4'(key_down), 4'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        base = pulses;
        tick(4);
        chk("rdeb_pulses", 4'(pulses - base), 4'h0);
        chk("rdeb_down", 4'(key_down), 4'h0);
        tick(1);
        chk("rdeb_accept", 4'(pulses - base), 4'h1);
        chk("rdeb_code", key_code, 4'h9);
        pressed = 16'h0000; settle(); tick(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad reader for a 4x4 switch array. It strobes columns one-hot active-low on a rotating pattern, with the same cadence and drive style as the anode scan of the display controller. It samples the row lines, debounces press and release, and reports one event per clean keypress. It sits between the board keypad pins and the user-logic input path, and shares the scan-rate `en` tick with the display controller.

## Interface
- `DEBOUNCE_TICKS`, default 4: consecutive `en` samples required to accept a press or a release; legal range 1..15.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  scan tick, one `clk` cycle wide. Upstream guarantees at least 4 `clk` cycles between ticks.
- `row`  in  4  keypad row lines, active-low (pulled up externally), asynchronous to `clk`.
- `col`  out  4  column strobes, active-low one-hot; `col[0]` is column 0.
- `key_code`  out  4  last accepted key, encoded as row_idx*4 + col_idx.
- `key_valid`  out  1  one-cycle pulse when a new key is accepted.
- `key_down`  out  1  high from acceptance of a press until acceptance of its release.

## Operation
- `row` passes through a 2-flop synchronizer (reset value 4'b1111). All decisions use the synchronized value `row_s`.
- Column strobe pattern for columns 0..3: 1110, 1101, 1011, 0111, then wraps to 1110.
- State machine with states SCAN, DEBOUNCE, HELD, RELEASE. Every transition and counter update happens only in a cycle with `en`=1. A cycle with `en`=0 holds all state.
- **SCAN**
  - On `en`, if `row_s` != 4'b1111: latch col_idx and row_idx, where row_idx is the lowest-index low row. Set cnt=1 and freeze `col`. If DEBOUNCE_TICKS=1, accept immediately and go to HELD; otherwise go to DEBOUNCE.
  - On `en` with no row low: advance `col` to the next column.
- **DEBOUNCE**
  - On `en`, if the latched row bit is low: cnt++. When cnt reaches DEBOUNCE_TICKS, accept and go to HELD.
  - If the latched row bit is high: go to SCAN and advance `col` to the next column. No event is reported.
- **Accept**
  - `key_code` <= row_idx*4 + col_idx.
  - `key_valid` pulses.
  - `key_down` <= 1.
- **HELD**
  - `col` stays frozen.
  - On `en` with the latched row bit high: set cnt=1 and go to RELEASE. If DEBOUNCE_TICKS=1, complete the release immediately instead.
- **RELEASE**
  - On `en` with the latched row bit high: cnt++. When cnt reaches DEBOUNCE_TICKS, set `key_down` <= 0, go to SCAN and advance `col`.
  - On `en` with the latched row bit low: return to HELD. No new `key_valid` is issued.
- While the column is frozen, other rows and keys are ignored (no rollover). `key_code` holds its value until the next accept.
- The counter is $clog2(DEBOUNCE_TICKS+1) bits wide and saturates; it never wraps.

## Timing
- Reset values:
  - `col`=4'b1110
  - `key_code`=4'h0
  - `key_valid`=0
  - `key_down`=0
  - state SCAN
  - cnt=0
  - synchronizer 4'b1111
- Reset assertion takes effect immediately and asynchronously from any state, including mid-DEBOUNCE or mid-RELEASE. No `key_valid` is emitted on reset or on reset release.
- Latency, `row` pin to `row_s`: 2 `clk` cycles.
- `key_valid` and `key_down` rise in the `clk` cycle after the `en` cycle holding the final accepting sample. `key_down` falls likewise after the final release sample.
- `col` updates in the `clk` cycle after `en`. The row is sampled on the next `en`, which gives at least 3 cycles of settle time.
- `key_valid` is a single-cycle pulse. Back-to-back pulses cannot occur because a release must complete between them.

## Structure
- Package `keypad_pkg`: state enum (SCAN, DEBOUNCE, HELD, RELEASE), constant COL_RESET = 4'b1110, constant ROWS_IDLE = 4'b1111.
- One sub-module, `sync_2ff`: 4-bit two-flop synchronizer with asynchronous active-low reset to all-ones.
- The top level holds the FSM, the column rotator, the priority encoder and the counter.

## Test plan
All scenarios use DEBOUNCE_TICKS=4 and `en` every 4 `clk` cycles.
- **Reset:** assert `rst_n`=0 mid-run → `col`=1110, `key_code`=0, `key_valid`=0, `key_down`=0 in the same cycle.
- **Idle scan:** no keys pressed, 5 `en` ticks → `col` steps 1110, 1101, 1011, 0111, 1110.
- **Clean press:** hold key row 2 / col 1 (`row`=1011 while `col`=1101) for 6 ticks → exactly one `key_valid`, `key_code`=9, `key_down`=1, `col` frozen at 1101.
- **Press bounce:** key low for 2 ticks, then high → no `key_valid`; `col` resumes at 1011.
- **Release bounce:** from HELD, release for 2 ticks, re-press, then release cleanly for 4 ticks → `key_down` stays 1 during the bounce with no second `key_valid`, then goes to 0 and `col` advances. Multi-key case: rows 1 and 3 pressed in column 0 → `key_code`=4.
- **Reset during DEBOUNCE:** assert reset after 2 press samples → state SCAN, `col`=1110. After reset deassert with the key still pressed, a fresh full debounce is required before `key_valid`.
